// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing/hazard controller.
// Holds the run-state enum, jump width default and the stage-control bundle.
package pipe_ctrl_pkg;

  localparam int JUMP_BITS_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_NONE      = '{ifid_stall: 1'b0, ifid_flush: 1'b0,
                                             idex_flush: 1'b0, exmem_flush: 1'b0};
  localparam stage_ctrl_t CTRL_FLUSH_ALL = '{ifid_stall: 1'b0, ifid_flush: 1'b1,
                                             idex_flush: 1'b1, exmem_flush: 1'b1};
  localparam stage_ctrl_t CTRL_BUBBLE    = '{ifid_stall: 1'b1, ifid_flush: 1'b0,
                                             idex_flush: 1'b1, exmem_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: compares decode sources against the
// destination of a load sitting in execute.
module hazard_detect #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2
) (
  input  logic                 exe_mem_read_i,
  input  logic                 exe_wr_i,
  input  logic [REGI_BITS-1:0] exe_dest_i,
  input  logic                 exe_dest_vec_i,
  input  logic [REGI_BITS-1:0] src_a_i,
  input  logic                 use_a_i,
  input  logic                 vec_a_i,
  input  logic [REGI_BITS-1:0] src_b_i,
  input  logic                 use_b_i,
  input  logic                 vec_b_i,
  output logic                 load_use_o
);

  logic match_a;
  logic match_b;
  logic idx_eq_a;
  logic idx_eq_b;

  // Vector file is smaller, so only its low index bits are significant.
  assign idx_eq_a = vec_a_i ? (src_a_i[VECT_BITS-1:0] == exe_dest_i[VECT_BITS-1:0])
                            : (src_a_i == exe_dest_i);
  assign idx_eq_b = vec_b_i ? (src_b_i[VECT_BITS-1:0] == exe_dest_i[VECT_BITS-1:0])
                            : (src_b_i == exe_dest_i);

  assign match_a = use_a_i & (vec_a_i == exe_dest_vec_i) & idx_eq_a;
  assign match_b = use_b_i & (vec_b_i == exe_dest_vec_i) & idx_eq_b;

  assign load_use_o = exe_mem_read_i & exe_wr_i & (match_a | match_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Run/halt sequencer, load-use bubbling and jump redirect for the 4-stage core.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int JUMP_BITS = JUMP_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [REGI_BITS-1:0] dec_src_a_i,
  input  logic [REGI_BITS-1:0] dec_src_b_i,
  input  logic                 dec_use_a_i,
  input  logic                 dec_use_b_i,
  input  logic                 dec_vec_a_i,
  input  logic                 dec_vec_b_i,
  input  logic                 exe_mem_read_i,
  input  logic                 exe_wr_i,
  input  logic [REGI_BITS-1:0] exe_dest_i,
  input  logic                 exe_dest_vec_i,
  input  logic                 mem_jump_i,
  input  logic [JUMP_BITS-1:0] mem_jump_addr_i,
  input  logic                 mem_end_i,
  output logic                 pc_we_o,
  output logic                 pc_sel_o,
  output logic [REGI_SIZE-1:0] pc_target_o,
  output logic                 ifid_stall_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic                 exmem_flush_o,
  output logic                 running_o,
  output logic                 halted_o,
  output logic [31:0]          perf_cycles_o,
  output logic [31:0]          perf_stalls_o,
  output logic [31:0]          perf_flushes_o
);

  state_e      state_q, state_d;
  stage_ctrl_t ctrl;
  logic        load_use;

  hazard_detect #(
    .REGI_BITS (REGI_BITS),
    .VECT_BITS (VECT_BITS)
  ) u_hazard_detect (
    .exe_mem_read_i (exe_mem_read_i),
    .exe_wr_i       (exe_wr_i),
    .exe_dest_i     (exe_dest_i),
    .exe_dest_vec_i (exe_dest_vec_i),
    .src_a_i        (dec_src_a_i),
    .use_a_i        (dec_use_a_i),
    .vec_a_i        (dec_vec_a_i),
    .src_b_i        (dec_src_b_i),
    .use_b_i        (dec_use_b_i),
    .vec_b_i        (dec_vec_b_i),
    .load_use_o     (load_use)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_we_o     = 1'b0;
    pc_sel_o    = 1'b0;
    pc_target_o = '0;
    ctrl        = CTRL_NONE;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        ctrl = CTRL_FLUSH_ALL;
        if (start_i) begin
          pc_we_o  = 1'b1;
          pc_sel_o = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mem_end_i) begin
          ctrl    = CTRL_FLUSH_ALL;
          state_d = ST_DRAIN;
        end else if (mem_jump_i) begin
          // A redirect squashes the instruction that caused any load-use stall.
          pc_we_o     = 1'b1;
          pc_sel_o    = 1'b1;
          pc_target_o = REGI_SIZE'(mem_jump_addr_i);
          ctrl        = CTRL_FLUSH_ALL;
        end else if (load_use) begin
          ctrl = CTRL_BUBBLE;
        end else begin
          pc_we_o = 1'b1;
        end
      end
      ST_DRAIN: begin
        ctrl    = CTRL_FLUSH_ALL;
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset forces the quiescent outputs before the state register settles.
    if (rst_i) begin
      state_d     = ST_IDLE;
      pc_we_o     = 1'b0;
      pc_sel_o    = 1'b0;
      pc_target_o = '0;
      ctrl        = CTRL_FLUSH_ALL;
    end
  end

  assign ifid_stall_o  = ctrl.ifid_stall;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_flush_o  = ctrl.idex_flush;
  assign exmem_flush_o = ctrl.exmem_flush;
  assign running_o     = (state_q == ST_RUN);
  assign halted_o      = (state_q == ST_HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cycles_q;
  logic [31:0] stalls_q;
  logic [31:0] flushes_q;
  logic        start_acc;
  logic        in_run;

  assign start_acc = start_i & ((state_q == ST_IDLE) | (state_q == ST_HALT));
  assign in_run    = (state_q == ST_RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      cycles_q  <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (in_run)                          cycles_q  <= cycles_q + 32'd1;
      if (in_run && ctrl.ifid_stall)       stalls_q  <= stalls_q + 32'd1;
      if (in_run && pc_we_o && pc_sel_o)   flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perf_cycles_o  = cycles_q;
  assign perf_stalls_o  = stalls_q;
  assign perf_flushes_o = flushes_q;
`else
  assign perf_cycles_o  = '0;
  assign perf_stalls_o  = '0;
  assign perf_flushes_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; perf expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  dec_src_a_i, dec_src_b_i;
  logic        dec_use_a_i, dec_use_b_i, dec_vec_a_i, dec_vec_b_i;
  logic        exe_mem_read_i, exe_wr_i, exe_dest_vec_i;
  logic [3:0]  exe_dest_i;
  logic        mem_jump_i, mem_end_i;
  logic [9:0]  mem_jump_addr_i;
  logic        pc_we_o, pc_sel_o, ifid_stall_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic        running_o, halted_o;
  logic [15:0] pc_target_o;
  logic [31:0] perf_cycles_o, perf_stalls_o, perf_flushes_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .dec_src_a_i     (dec_src_a_i),
    .dec_src_b_i     (dec_src_b_i),
    .dec_use_a_i     (dec_use_a_i),
    .dec_use_b_i     (dec_use_b_i),
    .dec_vec_a_i     (dec_vec_a_i),
    .dec_vec_b_i     (dec_vec_b_i),
    .exe_mem_read_i  (exe_mem_read_i),
    .exe_wr_i        (exe_wr_i),
    .exe_dest_i      (exe_dest_i),
    .exe_dest_vec_i  (exe_dest_vec_i),
    .mem_jump_i      (mem_jump_i),
    .mem_jump_addr_i (mem_jump_addr_i),
    .mem_end_i       (mem_end_i),
    .pc_we_o         (pc_we_o),
    .pc_sel_o        (pc_sel_o),
    .pc_target_o     (pc_target_o),
    .ifid_stall_o    (ifid_stall_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_flush_o    (idex_flush_o),
    .exmem_flush_o   (exmem_flush_o),
    .running_o       (running_o),
    .halted_o        (halted_o),
    .perf_cycles_o   (perf_cycles_o),
    .perf_stalls_o   (perf_stalls_o),
    .perf_flushes_o  (perf_flushes_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {stall, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [3:0] ctl();
    return {ifid_stall_o, ifid_flush_o, idex_flush_o, exmem_flush_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    start_i = 0; dec_src_a_i = 0; dec_src_b_i = 0; dec_use_a_i = 0; dec_use_b_i = 0;
    dec_vec_a_i = 0; dec_vec_b_i = 0; exe_mem_read_i = 0; exe_wr_i = 0;
    exe_dest_i = 0; exe_dest_vec_i = 0; mem_jump_i = 0; mem_jump_addr_i = 0; mem_end_i = 0;
  endtask

  task automatic load_in_exe(input logic [3:0] dest, input logic dvec);
    exe_mem_read_i = 1; exe_wr_i = 1; exe_dest_i = dest; exe_dest_vec_i = dvec;
  endtask

  initial begin
    clear_inputs();
    rst_i = 1;
    settle();
    chk("rst_pc_we_pre_edge", 32'(pc_we_o), 0);
    chk("rst_flush_pre_edge", 32'(ctl()), 32'h7);
    tick(); tick();
    chk("rst_running", 32'(running_o), 0);
    chk("rst_halted", 32'(halted_o), 0);
    chk("rst_perf_cycles", perf_cycles_o, 0);

    rst_i = 0;
    settle();
    chk("idle_flush", 32'(ctl()), 32'h7);
    chk("idle_pc_we", 32'(pc_we_o), 0);

    start_i = 1;
    settle();
    chk("start_pc_we", 32'(pc_we_o), 1);
    chk("start_pc_sel", 32'(pc_sel_o), 1);
    chk("start_target", 32'(pc_target_o), 0);
    tick();                                   // -> RUN
    start_i = 0;
    settle();
    // R1: plain run
    chk("run_running", 32'(running_o), 1);
    chk("run_pc_we", 32'(pc_we_o), 1);
    chk("run_pc_sel", 32'(pc_sel_o), 0);
    chk("run_ctl", 32'(ctl()), 0);
    tick();
    // R2: scalar load-use on A
    load_in_exe(4'd3, 1'b0); dec_src_a_i = 4'd3; dec_use_a_i = 1;
    settle();
    chk("lu_ctl", 32'(ctl()), 32'hA);
    chk("lu_pc_we", 32'(pc_we_o), 0);
    tick();
    // R3: load has moved on
    clear_inputs();
    settle();
    chk("lu_release_ctl", 32'(ctl()), 0);
    chk("lu_release_pc_we", 32'(pc_we_o), 1);
    tick();
    // R4: vector source vs scalar destination -> no hazard
    load_in_exe(4'd3, 1'b0); dec_src_a_i = 4'd3; dec_use_a_i = 1; dec_vec_a_i = 1;
    settle();
    chk("vec_mismatch_stall", 32'(ifid_stall_o), 0);
    chk("vec_mismatch_pc_we", 32'(pc_we_o), 1);
    tick();
    // R5: vector compare uses only the low two index bits, via B
    clear_inputs();
    load_in_exe(4'b0111, 1'b1); dec_src_b_i = 4'b1011; dec_use_b_i = 1; dec_vec_b_i = 1;
    settle();
    chk("vec_low_bits_ctl", 32'(ctl()), 32'hA);
    tick();
    // R6: matching index but source unused -> no hazard
    clear_inputs();
    load_in_exe(4'd5, 1'b0); dec_src_b_i = 4'd5; dec_use_b_i = 0; dec_src_a_i = 4'd6; dec_use_a_i = 1;
    settle();
    chk("unused_src_stall", 32'(ifid_stall_o), 0);
    tick();
    // R7: jump beats a simultaneous load-use
    clear_inputs();
    load_in_exe(4'd3, 1'b0); dec_src_a_i = 4'd3; dec_use_a_i = 1;
    mem_jump_i = 1; mem_jump_addr_i = 10'h2A5;
    settle();
    chk("jump_target", 32'(pc_target_o), 32'h02A5);
    chk("jump_pc_we", 32'(pc_we_o), 1);
    chk("jump_pc_sel", 32'(pc_sel_o), 1);
    chk("jump_ctl", 32'(ctl()), 32'h7);
    tick();
    // R8..R10: plain run
    clear_inputs();
    tick(); tick(); tick();
    settle();
    chk("perf_cycles_10", perf_cycles_o, PERF ? 32'd10 : 32'd0);
    chk("perf_stalls_2", perf_stalls_o, PERF ? 32'd2 : 32'd0);
    chk("perf_flushes_1", perf_flushes_o, PERF ? 32'd1 : 32'd0);
    // R11: end wins over a jump in the same cycle
    mem_end_i = 1; mem_jump_i = 1; mem_jump_addr_i = 10'h111;
    settle();
    chk("end_pc_we", 32'(pc_we_o), 0);
    chk("end_ctl", 32'(ctl()), 32'h7);
    tick();                                   // -> DRAIN
    clear_inputs();
    start_i = 1;
    settle();
    chk("drain_running", 32'(running_o), 0);
    chk("drain_halted", 32'(halted_o), 0);
    chk("drain_ignores_start", 32'(pc_we_o), 0);
    chk("drain_ctl", 32'(ctl()), 32'h7);
    tick();                                   // -> HALT
    start_i = 0;
    settle();
    chk("halt_halted", 32'(halted_o), 1);
    chk("halt_pc_we", 32'(pc_we_o), 0);
    chk("halt_ctl", 32'(ctl()), 32'h7);
    chk("halt_perf_cycles", perf_cycles_o, PERF ? 32'd11 : 32'd0);
    start_i = 1;
    settle();
    chk("restart_pc_we", 32'(pc_we_o), 1);
    chk("restart_pc_sel", 32'(pc_sel_o), 1);
    chk("restart_target", 32'(pc_target_o), 0);
    tick();                                   // -> RUN, counters cleared
    start_i = 0;
    settle();
    chk("restart_running", 32'(running_o), 1);
    chk("restart_halted", 32'(halted_o), 0);
    chk("restart_perf_clear", perf_stalls_o | perf_flushes_o | perf_cycles_o, 0);
    tick();
    // Reset with a jump pending
    mem_jump_i = 1; mem_jump_addr_i = 10'h3FF;
    settle();
    chk("pend_jump_target", 32'(pc_target_o), 32'h03FF);
    rst_i = 1;
    settle();
    chk("mid_rst_pc_we", 32'(pc_we_o), 0);
    chk("mid_rst_ctl", 32'(ctl()), 32'h7);
    tick();
    settle();
    chk("mid_rst_running", 32'(running_o), 0);
    chk("mid_rst_perf", perf_cycles_o, 0);
    rst_i = 0;
    clear_inputs();
    settle();
    chk("post_rst_idle_ctl", 32'(ctl()), 32'h7);
    chk("post_rst_pc_we", 32'(pc_we_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
